reaction_timing_state: RTL and testbench

Measurement state of the reaction timer, and the producer of the 3-digit BCD score that the high-score state consumes. When enabled it waits a pseudo-random delay, lights the stimulus LED, and counts milliseconds until the player presses KEY[0]. It then freezes the score on `score_c/b/a` and drives `out_state` to hand control to the high-score state. It also handles false starts and the 999 ms timeout, and drives the live count onto HEX0–HEX2.

---
 rtl/reaction_timing_state.sv | 182 ++++++++++++++++++
 tb/tb_reaction_timing_state.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timing_state.sv
// Reaction timer measurement state: random pre-delay, stimulus LED,
// millisecond BCD count of the reaction, score hand-off and timeout.
module reaction_timing_state #(
  parameter int         TICK_DIV     = 50000,
  parameter int         MIN_DELAY_MS = 1000,
  parameter int         RAND_BITS    = 12,
  parameter logic [3:0] STATE_SELF   = 4'd2,
  parameter logic [3:0] STATE_NEXT   = 4'd3,
  parameter logic [3:0] STATE_ABORT  = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] KEY,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [3:0] score_c,
  output logic       stim,
  output logic [7:0] HEX0,
  output logic [7:0] HEX1,
  output logic [7:0] HEX2,
  output logic [3:0] out_state
);

  localparam int DLY_MAX = MIN_DELAY_MS + (1 << RAND_BITS) - 1;
  localparam int DW_RAW  = $clog2(DLY_MAX + 1);
  localparam int DW      = (DW_RAW > RAND_BITS + 1) ? DW_RAW : RAND_BITS + 1;
  localparam int DIVW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_GO    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd5;

  logic [2:0]      state_q;
  logic [DW-1:0]   delay_q;
  logic [DIVW-1:0] div_q;
  logic [15:0]     lfsr_q;
  logic            s1_q, s2_q, s3_q, press_q;
  logic [3:0]      cnt_a, cnt_b, cnt_c;
  logic [3:0]      nxt_a, nxt_b, nxt_c;
  logic            tick;
  logic            cnt_max;
  logic            unused_key;

  assign unused_key = KEY[1];

  // Only the first falling edge per phase matters, so no debounce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
      press_q <= 1'b0;
    end else begin
      s1_q    <= KEY[0];
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      press_q <= s3_q & ~s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr_q <= 16'hACE1;
    else
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                 lfsr_q[15:1]};
  end

  assign tick = (state_q != S_IDLE) &&
                (div_q == DIVW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      div_q <= '0;
    else if (state_q == S_IDLE || tick)
      div_q <= '0;
    else
      div_q <= div_q + DIVW'(1);
  end

  always_comb begin
    nxt_a = cnt_a + 4'd1;
    nxt_b = cnt_b;
    nxt_c = cnt_c;
    if (cnt_a == 4'd9) begin
      nxt_a = 4'd0;
      nxt_b = cnt_b + 4'd1;
      if (cnt_b == 4'd9) begin
        nxt_b = 4'd0;
        nxt_c = cnt_c + 4'd1;
      end
    end
  end

  assign cnt_max = ({cnt_c, cnt_b, cnt_a} == 12'h999);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      delay_q <= '0;
      {cnt_c, cnt_b, cnt_a}       <= '0;
      {score_c, score_b, score_a} <= '0;
    end else if (!en) begin
      state_q <= S_IDLE;
      delay_q <= '0;
      {cnt_c, cnt_b, cnt_a} <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: state_q <= S_ARM;
        S_ARM: begin
          delay_q <= DW'(MIN_DELAY_MS) +
                     DW'(lfsr_q[RAND_BITS-1:0]);
          {cnt_c, cnt_b, cnt_a}       <= '0;
          {score_c, score_b, score_a} <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (press_q) begin
            {score_c, score_b, score_a} <= '0;
            state_q <= S_FAULT;
          end else if (tick) begin
            delay_q <= delay_q - DW'(1);
            if (delay_q <= DW'(1))
              state_q <= S_GO;
          end
        end
        // A press beats a same-cycle tick; 999 saturates instead of wrapping.
        S_GO: begin
          if (press_q) begin
            {score_c, score_b, score_a} <= {cnt_c, cnt_b, cnt_a};
            state_q <= S_DONE;
          end else if (tick) begin
            if (cnt_max) begin
              {score_c, score_b, score_a} <= 12'h999;
              state_q <= S_DONE;
            end else begin
              {cnt_c, cnt_b, cnt_a} <= {nxt_c, nxt_b, nxt_a};
            end
          end
        end
        S_DONE:  state_q <= S_DONE;
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stim = (state_q == S_GO);

  always_comb begin
    unique case (state_q)
      S_DONE:  out_state = STATE_NEXT;
      S_FAULT: out_state = STATE_ABORT;
      default: out_state = STATE_SELF;
    endcase
  end

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign HEX0 = seg7(cnt_a);
  assign HEX1 = seg7(cnt_b);
  assign HEX2 = seg7(cnt_c);

endmodule

// File: tb/tb_reaction_timing_state.sv
// Bench for reaction_timing_state: cycle model compared every cycle
// plus directed scenarios with literal expectations.
module tb_reaction_timing_state;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] KEY = 2'b11;
  logic [3:0] score_a, score_b, score_c;
  logic       stim;
  logic [7:0] HEX0, HEX1, HEX2;
  logic [3:0] out_state;

  int checks = 0;
  int failures = 0;

  reaction_timing_state #(
    .TICK_DIV(4), .MIN_DELAY_MS(5), .RAND_BITS(2),
    .STATE_SELF(4'd2), .STATE_NEXT(4'd3), .STATE_ABORT(4'd0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .KEY(KEY),
    .score_a(score_a), .score_b(score_b), .score_c(score_c),
    .stim(stim), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
    .out_state(out_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hex7(input int d);
    case (d)
      0: hex7 = 8'hC0;  1: hex7 = 8'hF9;  2: hex7 = 8'hA4;
      3: hex7 = 8'hB0;  4: hex7 = 8'h99;  5: hex7 = 8'h92;
      6: hex7 = 8'h82;  7: hex7 = 8'hF8;  8: hex7 = 8'h80;
      9: hex7 = 8'h90;  default: hex7 = 8'hFF;
    endcase
  endfunction

  // Model: phases as small ints, ms count and score as plain integers.
  localparam int M_IDLE = 0, M_ARM = 1, M_WAIT = 2;
  localparam int M_GO = 3, M_DONE = 4, M_FAULT = 5;

  int          m_mode = M_IDLE;
  int          m_t = 0;
  int          m_rem = 0;
  int          m_cnt = 0;
  int          m_score = 0;
  logic [15:0] m_lfsr = 16'hACE1;
  logic [3:0]  kh = 4'hF;
  bit          m_pr, m_tk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; m_t = 0; m_rem = 0;
      m_cnt = 0; m_score = 0;
      m_lfsr = 16'hACE1; kh = 4'hF;
    end else begin
      m_pr = kh[3] & ~kh[2];
      m_tk = (m_mode != M_IDLE) && (m_t % 4 == 3);
      if (!en) begin
        m_mode = M_IDLE;
        m_cnt = 0;
      end else begin
        case (m_mode)
          M_IDLE: begin m_mode = M_ARM; m_t = -1; end
          M_ARM: begin
            m_rem = 5 + int'(m_lfsr % 16'd4);
            m_score = 0; m_cnt = 0; m_mode = M_WAIT;
          end
          M_WAIT:
            if (m_pr) begin m_mode = M_FAULT; m_score = 0; end
            else if (m_tk) begin
              m_rem--;
              if (m_rem == 0) m_mode = M_GO;
            end
          M_GO:
            if (m_pr) begin m_mode = M_DONE; m_score = m_cnt; end
            else if (m_tk) begin
              if (m_cnt == 999) begin m_mode = M_DONE; m_score = 999; end
              else m_cnt++;
            end
          default: ;
        endcase
      end
      m_t++;
      m_lfsr = (m_lfsr >> 1) | (16'(^(m_lfsr & 16'h002D)) << 15);
      kh = {kh[2:0], KEY[0]};
    end
  end

  bit stim_seen = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stim) stim_seen = 1;
      chk("stim", stim, m_mode == M_GO);
      chk("out_state", out_state,
          m_mode == M_DONE ? 3 : (m_mode == M_FAULT ? 0 : 2));
      chk("score", {score_c, score_b, score_a},
          ((m_score / 100) << 8) | (((m_score / 10) % 10) << 4) | (m_score % 10));
      chk("hex", {HEX2, HEX1, HEX0},
          {hex7(m_cnt / 100), hex7((m_cnt / 10) % 10), hex7(m_cnt % 10)});
    end
  end

  task automatic wait_stim(output int n);
    n = 0;
    while (!stim && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!stim) chk("stim_timeout", stim, 1);
  endtask

  // Raise en and return the negedge count until stim; onset must be 1+4D.
  task automatic start_run();
    int n;
    en = 1'b1;
    wait_stim(n);
    chk("onset_align", (n - 1) % 4, 0);
    chk("onset_range", int'((n - 1) / 4 >= 5 && (n - 1) / 4 <= 8), 1);
  endtask

  task automatic stop_run();
    KEY = 2'b11;
    en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_stim", stim, 0);
    chk("rst_score", {score_c, score_b, score_a}, 0);
    chk("rst_out", out_state, 2);
    chk("rst_hex", {HEX2, HEX1, HEX0}, 24'hC0C0C0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Press lands between GO ticks 37 and 38.
    start_run();
    repeat (146) @(negedge clk);
    KEY = 2'b10;
    repeat (6) @(negedge clk);
    chk("r37_score", {score_c, score_b, score_a}, 12'h037);
    chk("r37_out", out_state, 3);
    chk("r37_stim", stim, 0);
    stop_run();
    chk("r37_held", {score_c, score_b, score_a}, 12'h037);
    chk("r37_idle_hex", HEX0, 8'hC0);

    // False start.
    stim_seen = 0;
    en = 1'b1;
    repeat (8) @(negedge clk);
    KEY = 2'b10;
    repeat (8) @(negedge clk);
    chk("fault_out", out_state, 0);
    chk("fault_score", {score_c, score_b, score_a}, 0);
    chk("fault_stim_seen", int'(stim_seen), 0);
    stop_run();

    // Press on the same cycle as GO tick 42.
    start_run();
    repeat (164) @(negedge clk);
    KEY = 2'b10;
    repeat (6) @(negedge clk);
    chk("r41_score", {score_c, score_b, score_a}, 12'h041);
    chk("r41_out", out_state, 3);
    stop_run();

    // Re-arm clears the held score; abort mid-GO, then rerun.
    en = 1'b1;
    repeat (4) @(negedge clk);
    chk("arm_clear", {score_c, score_b, score_a}, 0);
    wait_stim(n);
    repeat (20) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_stim", stim, 0);
    chk("abort_out", out_state, 2);
    start_run();
    stop_run();

    // Timeout saturates at 999 after 4000 cycles of GO.
    start_run();
    n = 0;
    while (out_state != 4'd3 && n < 4100) begin
      @(negedge clk);
      n++;
    end
    chk("sat_cycles", n, 4000);
    chk("sat_score", {score_c, score_b, score_a}, 12'h999);
    repeat (40) @(negedge clk);
    chk("sat_hold", {score_c, score_b, score_a}, 12'h999);
    chk("sat_out", out_state, 3);
    chk("sat_hex", {HEX2, HEX1, HEX0}, 24'h909090);
    stop_run();

    // Asynchronous reset in the middle of GO.
    start_run();
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stim", stim, 0);
    chk("arst_score", {score_c, score_b, score_a}, 0);
    chk("arst_out", out_state, 2);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_idle_out", out_state, 2);
    chk("arst_idle_stim", stim, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
